// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b memory types: word/byte/mask types plus responder FSM state and latency counter.
// The optional LC3B_MEM_BOUNDS_EN build adds no types here.
package lc3b_mem_responder_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [7:0]  lc3b_byte;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        mem_idle,
        mem_busy,
        mem_resp_s
    } lc3b_mem_state;

    typedef logic [3:0] lc3b_mem_lat;

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// Datapath-to-memory handshake bundle (mem_read/mem_write/mem_wmask/mem_resp).
// With LC3B_MEM_BOUNDS_EN defined the bundle also carries mem_err.
interface lc3b_mem_responder_if;
    import lc3b_mem_responder_pkg::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_wmask;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    logic          mem_resp;
    lc3b_word      mem_rdata;
`ifdef LC3B_MEM_BOUNDS_EN
    logic          mem_err;
`endif

    modport master (
        output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
`ifdef LC3B_MEM_BOUNDS_EN
        , input mem_err
`endif
    );

    modport slave (
        input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        output mem_resp, mem_rdata
`ifdef LC3B_MEM_BOUNDS_EN
        , output mem_err
`endif
    );

endinterface

// File: rtl/lc3b_mem_responder_bytemask_sram.sv
// Single-port word array with per-byte write enables and a combinational read.
// Contents are never reset; unaffected by LC3B_MEM_BOUNDS_EN.
module lc3b_bytemask_sram
    import lc3b_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] index,
    input  lc3b_mem_wmask        byte_we,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);

    lc3b_word array [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (byte_we[0]) array[index][7:0]  <= wdata[7:0];
        if (byte_we[1]) array[index][15:8] <= wdata[15:8];
    end

    assign rdata = array[index];

endmodule

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency memory responder for the LC-3b datapath memory port.
// Define LC3B_MEM_BOUNDS_EN to flag (mem_err) and neutralise accesses above the array.
module lc3b_mem_responder
    import lc3b_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input logic                 clk,
    input logic                 reset_n,
    lc3b_mem_responder_if.slave bus
);

    lc3b_mem_state        state;
    lc3b_mem_lat          count;
    logic [ADDR_BITS-1:0] req_index;
    lc3b_mem_wmask        req_wmask;
    lc3b_word             req_wdata;
    logic                 req_read;
    logic                 req_write;
    logic                 req_oob;
    logic                 resp_q;
    lc3b_word             rdata_q;
    logic                 err_q;

    logic                 cur_read;
    logic                 cur_oob;
    logic                 enter_resp;
    logic [ADDR_BITS-1:0] sram_index;
    lc3b_mem_wmask        sram_we;
    lc3b_word             sram_rdata;
    logic                 live_oob;

`ifdef LC3B_MEM_BOUNDS_EN
    assign live_oob = |bus.mem_address[15:ADDR_BITS+1];
`else
    assign live_oob = 1'b0;
`endif

    // In IDLE the array is addressed straight from the bus so a LATENCY==1 request can load rdata on acceptance.
    always_comb begin
        cur_read   = req_read;
        cur_oob    = req_oob;
        sram_index = req_index;
        enter_resp = 1'b0;
        case (state)
            mem_idle: begin
                cur_read   = bus.mem_read;
                cur_oob    = live_oob;
                sram_index = bus.mem_address[ADDR_BITS:1];
                enter_resp = (LATENCY == 1) && (bus.mem_read || bus.mem_write);
            end
            mem_busy: enter_resp = (count == 4'd1);
            default:  enter_resp = 1'b0;
        endcase
    end

    assign sram_we = (state == mem_resp_s && req_write && !req_oob && reset_n) ? req_wmask : 2'b00;

    lc3b_bytemask_sram #(.ADDR_BITS(ADDR_BITS)) u_sram (
        .clk     (clk),
        .index   (sram_index),
        .byte_we (sram_we),
        .wdata   (req_wdata),
        .rdata   (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= mem_idle;
            count   <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                mem_idle: begin
                    if (bus.mem_read || bus.mem_write) begin
                        req_index <= bus.mem_address[ADDR_BITS:1];
                        req_wmask <= bus.mem_wmask;
                        req_wdata <= bus.mem_wdata;
                        req_read  <= bus.mem_read;
                        req_write <= bus.mem_write;
                        req_oob   <= live_oob;
                        count     <= lc3b_mem_lat'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? mem_resp_s : mem_busy;
                    end
                end
                mem_busy: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) state <= mem_resp_s;
                end
                default: state <= mem_idle;
            endcase
            resp_q <= enter_resp;
            err_q  <= enter_resp && cur_oob;
            // A combined read+write also returns the word as it stood before the write.
            if (enter_resp && cur_read) rdata_q <= cur_oob ? 16'h0000 : sram_rdata;
        end
    end

    assign bus.mem_resp  = resp_q;
    assign bus.mem_rdata = rdata_q;
`ifdef LC3B_MEM_BOUNDS_EN
    assign bus.mem_err   = err_q;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed self-checking bench for lc3b_mem_responder (LATENCY=3 and LATENCY=1 instances).
// Bounds checks follow LC3B_MEM_BOUNDS_EN when it is defined.
module tb_lc3b_mem_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lc3b_mem_responder_if bus ();
    lc3b_mem_responder_if bus1 ();

    lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    // Issue one request on the LATENCY=3 port, wait for mem_resp, drop it and sample one cycle later.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wd, input logic [1:0] mask,
                                 output int cycles, output logic [15:0] rdata,
                                 output logic err, output logic one_cycle);
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.mem_address = addr;
        bus.mem_wdata = wd;
        bus.mem_wmask = mask;
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin
                cycles = i;
                break;
            end
        end
        rdata = bus.mem_rdata;
`ifdef LC3B_MEM_BOUNDS_EN
        err = bus.mem_err;
`else
        err = 1'b0;
`endif
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk); #1;
        one_cycle = !bus.mem_resp;
    endtask

    task automatic test_reset();
        int n; logic [15:0] rd; logic er; logic oc;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp got %b expected 0", bus.mem_resp); end
        checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata got %h expected 0000", bus.mem_rdata); end
`ifdef LC3B_MEM_BOUNDS_EN
        checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b expected 0", bus.mem_err); end
`endif
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL reset_read_latency got %0d expected 3", n); end
        checks++; if (oc !== 1'b1) begin errors++; $display("[TB] FAIL reset_read_pulse got %b expected 1", oc); end
    endtask

    task automatic test_full_write_read();
        int n; logic [15:0] rd; logic er; logic oc;
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, n, rd, er, oc);
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL wr_latency got %0d expected 3", n); end
        checks++; if (oc !== 1'b1) begin errors++; $display("[TB] FAIL wr_pulse got %b expected 1", oc); end
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL rd_latency got %0d expected 3", n); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_full got %h expected BEEF", rd); end
        checks++; if (oc !== 1'b1) begin errors++; $display("[TB] FAIL rd_pulse got %b expected 1", oc); end
    endtask

    task automatic test_byte_writes();
        int n; logic [15:0] rd; logic er; logic oc;
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h00AA, 2'b01, n, rd, er, oc);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("[TB] FAIL rdata_held_on_write got %h expected BEEF", rd); end
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h5500, 2'b10, n, rd, er, oc);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (rd !== 16'h55AA) begin errors++; $display("[TB] FAIL byte_merge got %h expected 55AA", rd); end
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, n, rd, er, oc);
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL mask00_latency got %0d expected 3", n); end
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (rd !== 16'h55AA) begin errors++; $display("[TB] FAIL mask00_nowrite got %h expected 55AA", rd); end
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1111, 2'b11, n, rd, er, oc);
        checks++; if (rd !== 16'h55AA) begin errors++; $display("[TB] FAIL rw_prewrite got %h expected 55AA", rd); end
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (rd !== 16'h1111) begin errors++; $display("[TB] FAIL rw_written got %h expected 1111", rd); end
    endtask

    task automatic test_back_to_back();
        int n1; int n2; logic [15:0] rd;
        bus.mem_read = 1'b1;
        bus.mem_address = 16'h0010;
        n1 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin n1 = i; break; end
        end
        checks++; if (n1 !== 3) begin errors++; $display("[TB] FAIL b2b_first got %0d expected 3", n1); end
        n2 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin n2 = i; break; end
        end
        checks++; if (n2 !== 4) begin errors++; $display("[TB] FAIL b2b_spacing got %0d expected 4", n2); end
        checks++; if (bus.mem_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL b2b_data got %h expected BEEF", bus.mem_rdata); end
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        // Address moved while BUSY must not redirect the latched read.
        bus.mem_read = 1'b1;
        bus.mem_address = 16'h0010;
        @(posedge clk); #1;
        bus.mem_address = 16'h0020;
        n1 = -1;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.mem_resp) begin n1 = i; break; end
        end
        rd = bus.mem_rdata;
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        checks++; if (n1 !== 3) begin errors++; $display("[TB] FAIL busy_change_latency got %0d expected 3", n1); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("[TB] FAIL busy_change_data got %h expected BEEF", rd); end
    endtask

    task automatic test_reset_mid_op();
        int n; logic [15:0] rd; logic er; logic oc; logic seen;
        bus.mem_write = 1'b1;
        bus.mem_address = 16'h0010;
        bus.mem_wdata = 16'hDEAD;
        bus.mem_wmask = 2'b11;
        @(posedge clk); #1;
        reset_n = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL midop_rdata_clr got %h expected 0000", bus.mem_rdata); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.mem_resp) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midop_no_resp got %b expected 0", seen); end
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("[TB] FAIL midop_no_write got %h expected BEEF", rd); end
    endtask

    task automatic test_latency_one();
        bus1.mem_read = 1'b0;
        bus1.mem_write = 1'b1;
        bus1.mem_address = 16'h0004;
        bus1.mem_wdata = 16'h1357;
        bus1.mem_wmask = 2'b11;
        @(posedge clk); #1;
        checks++; if (bus1.mem_resp !== 1'b1) begin errors++; $display("[TB] FAIL lat1_write_resp got %b expected 1", bus1.mem_resp); end
        bus1.mem_write = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus1.mem_resp !== 1'b0) begin errors++; $display("[TB] FAIL lat1_pulse got %b expected 0", bus1.mem_resp); end
        bus1.mem_read = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus1.mem_resp !== 1'b1) begin errors++; $display("[TB] FAIL lat1_read_resp got %b expected 1", bus1.mem_resp); end
        checks++; if (bus1.mem_rdata !== 16'h1357) begin errors++; $display("[TB] FAIL lat1_data got %h expected 1357", bus1.mem_rdata); end
        bus1.mem_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_bounds();
        int n; logic [15:0] rd; logic er; logic oc;
        applyStimulus(1'b0, 1'b1, 16'h0002, 16'hCAFE, 2'b11, n, rd, er, oc);
        applyStimulus(1'b0, 1'b1, 16'h0802, 16'h1234, 2'b11, n, rd, er, oc);
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL oob_write_latency got %0d expected 3", n); end
`ifdef LC3B_MEM_BOUNDS_EN
        checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL oob_write_err got %b expected 1", er); end
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (rd !== 16'hCAFE) begin errors++; $display("[TB] FAIL oob_write_suppressed got %h expected CAFE", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL inrange_err got %b expected 0", er); end
        applyStimulus(1'b1, 1'b0, 16'h0802, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (rd !== 16'h0000) begin errors++; $display("[TB] FAIL oob_read_data got %h expected 0000", rd); end
        checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL oob_read_err got %b expected 1", er); end
`else
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (rd !== 16'h1234) begin errors++; $display("[TB] FAIL alias_low got %h expected 1234", rd); end
        applyStimulus(1'b1, 1'b0, 16'h0802, 16'h0000, 2'b00, n, rd, er, oc);
        checks++; if (rd !== 16'h1234) begin errors++; $display("[TB] FAIL alias_high got %h expected 1234", rd); end
`endif
    endtask

    initial begin
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wmask = 2'b00;
        bus.mem_address = 16'h0000;
        bus.mem_wdata = 16'h0000;
        bus1.mem_read = 1'b0;
        bus1.mem_write = 1'b0;
        bus1.mem_wmask = 2'b00;
        bus1.mem_address = 16'h0000;
        bus1.mem_wdata = 16'h0000;
        test_reset();
        test_full_write_read();
        test_byte_writes();
        test_back_to_back();
        test_reset_mid_op();
        test_latency_one();
        test_bounds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
